fifo_wr_ctrl: RTL and testbench

Write-side controller for the dual-clock FIFO; sits directly upstream of the dual-clock RAM and drives its write enable, write address and write data.
- Accepts a push/data stream from the producer.
- Maintains the binary and Gray write pointers.
- Synchronises the read-domain Gray pointer into the write domain.
- Produces registered full, almost_full, fill-level and sticky overflow status.
- Runs entirely in the write clock domain.

---
 rtl/fifo_pkg.sv | 27 ++
 rtl/ptr_sync.sv | 31 +++
 rtl/fifo_wr_ctrl.sv | 102 ++++++++++
 tb/tb_fifo_wr_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared types, sizing and pointer-code helpers for both sides of the dual-clock FIFO.
// The read-side controller imports the same Gray conversions so both domains agree on the encoding.
package fifo_pkg;

    localparam int W_DATA  = 8;
    localparam int W_DEPTH = 16;
    localparam int W_ADDR  = $clog2(W_DEPTH);

    typedef logic [W_DATA-1:0] data_t;
    typedef logic [W_ADDR-1:0] addr_t;
    // One extra bit beyond the address distinguishes a full lap from empty.
    typedef logic [W_ADDR:0]   ptr_t;

    function automatic ptr_t bin2gray(input ptr_t b);
        return b ^ (b >> 1);
    endfunction

    function automatic ptr_t gray2bin(input ptr_t g);
        ptr_t b;
        b[W_ADDR] = g[W_ADDR];
        for (int i = W_ADDR - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/ptr_sync.sv
// Multi-flop synchronizer carrying a Gray-coded pointer into the local clock domain.
// Used by the write side for the read pointer and by the read side for the write pointer.
module ptr_sync
    import fifo_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  ptr_t i_ptr,
    output ptr_t o_ptr
);

    ptr_t r_chain [SYNC_STAGES];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_chain[i] <= '0;
            end
        end else begin
            r_chain[0] <= i_ptr;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_chain[i] <= r_chain[i-1];
            end
        end
    end

    assign o_ptr = r_chain[SYNC_STAGES-1];

endmodule

// File: rtl/fifo_wr_ctrl.sv
// Write-side controller of the dual-clock FIFO: accepts pushes, drives the RAM write port,
// and keeps pessimistic full / almost-full / fill-level / overflow status in the write domain.
module fifo_wr_ctrl
    import fifo_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int AFULL_LVL   = 2
) (
    input  logic  clk_wr,
    input  logic  rst,
    input  logic  push,
    input  data_t push_data,
    input  logic  clr_ovf,
    input  ptr_t  rd_ptr_gray,
    output logic  en_wr,
    output addr_t addr_wr,
    output data_t data_wr,
    output ptr_t  wr_ptr_gray,
    output logic  full,
    output logic  almost_full,
    output ptr_t  used,
    output logic  overflow
);

    ptr_t r_ptr_bin;
    ptr_t r_ptr_gray;
    logic r_full;
    logic r_afull;
    ptr_t r_used;
    logic r_ovf;

    logic w_acc;
    logic w_drop;
    ptr_t w_ptr_bin_next;
    ptr_t w_ptr_gray_next;
    ptr_t w_rd_gray_s;
    ptr_t w_rd_bin_s;
    ptr_t w_full_gray;
    logic w_full_next;
    ptr_t w_used_next;
    logic w_afull_next;

    ptr_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_rd_sync (
        .i_clk (clk_wr),
        .i_rst (rst),
        .i_ptr (rd_ptr_gray),
        .o_ptr (w_rd_gray_s)
    );

    // Gating with rst keeps the RAM from being written while the pointer is held in reset.
    assign w_acc  = push & ~r_full & ~rst;
    assign w_drop = push & r_full;

    assign w_ptr_bin_next  = r_ptr_bin + ptr_t'(w_acc);
    assign w_ptr_gray_next = bin2gray(w_ptr_bin_next);
    assign w_rd_bin_s      = gray2bin(w_rd_gray_s);

    // Full when the writer is exactly one lap ahead: top two Gray bits inverted, rest equal.
    assign w_full_gray  = {~w_rd_gray_s[W_ADDR:W_ADDR-1], w_rd_gray_s[W_ADDR-2:0]};
    assign w_full_next  = (w_ptr_gray_next == w_full_gray);
    assign w_used_next  = w_ptr_bin_next - w_rd_bin_s;
    assign w_afull_next = (w_used_next >= ptr_t'(W_DEPTH - AFULL_LVL));

    always_ff @(posedge clk_wr or posedge rst) begin
        if (rst) begin
            r_ptr_bin  <= '0;
            r_ptr_gray <= '0;
            r_full     <= 1'b0;
            r_afull    <= 1'b0;
            r_used     <= '0;
        end else begin
            r_ptr_bin  <= w_ptr_bin_next;
            r_ptr_gray <= w_ptr_gray_next;
            r_full     <= w_full_next;
            r_afull    <= w_afull_next;
            r_used     <= w_used_next;
        end
    end

    // A dropped push in the same cycle as a clear request leaves the flag set.
    always_ff @(posedge clk_wr or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end else if (clr_ovf) begin
            r_ovf <= 1'b0;
        end
    end

    assign en_wr       = w_acc;
    assign addr_wr     = r_ptr_bin[W_ADDR-1:0];
    assign data_wr     = push_data;
    assign wr_ptr_gray = r_ptr_gray;
    assign full        = r_full;
    assign almost_full = r_afull;
    assign used        = r_used;
    assign overflow    = r_ovf;

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Directed bench for fifo_wr_ctrl: fill/overflow, overflow clear, read advance through the
// synchronizer, almost-full threshold, reader tracking with pointer wrap, and async reset.
module tb_fifo_wr_ctrl;
    import fifo_pkg::*;

    logic  clk_wr = 1'b0;
    logic  rst;
    logic  push;
    data_t push_data;
    logic  clr_ovf;
    ptr_t  rd_ptr_gray;
    logic  en_wr;
    addr_t addr_wr;
    data_t data_wr;
    ptr_t  wr_ptr_gray;
    logic  full;
    logic  almost_full;
    ptr_t  used;
    logic  overflow;

    ptr_t  rd_drv;
    logic  track;
    ptr_t  trk_d1;
    ptr_t  trk_d2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_wr = ~clk_wr;

    fifo_wr_ctrl #(
        .SYNC_STAGES(2),
        .AFULL_LVL  (2)
    ) dut (
        .clk_wr     (clk_wr),
        .rst        (rst),
        .push       (push),
        .push_data  (push_data),
        .clr_ovf    (clr_ovf),
        .rd_ptr_gray(rd_ptr_gray),
        .en_wr      (en_wr),
        .addr_wr    (addr_wr),
        .data_wr    (data_wr),
        .wr_ptr_gray(wr_ptr_gray),
        .full       (full),
        .almost_full(almost_full),
        .used       (used),
        .overflow   (overflow)
    );

    // Two-cycle model of a reader that consumes right behind the writer.
    always @(posedge clk_wr or posedge rst) begin
        if (rst) begin
            trk_d1 <= '0;
            trk_d2 <= '0;
        end else begin
            trk_d1 <= wr_ptr_gray;
            trk_d2 <= trk_d1;
        end
    end

    assign rd_ptr_gray = track ? trk_d2 : rd_drv;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_wr);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        push      = 1'b0;
        push_data = '0;
        clr_ovf   = 1'b0;
        rd_drv    = '0;
        track     = 1'b0;

        #12;
        check("rst_full",  32'(full), 32'd0);
        check("rst_used",  32'(used), 32'd0);
        check("rst_gray",  32'(wr_ptr_gray), 32'd0);
        check("rst_ovf",   32'(overflow), 32'd0);
        check("rst_en",    32'(en_wr), 32'd0);
        check("rst_afull", 32'(almost_full), 32'd0);
        tick();
        rst = 1'b0;

        // Fill 16 words with the read pointer parked at 0.
        for (int i = 0; i < 16; i++) begin
            push      = 1'b1;
            push_data = data_t'(8'hA0 + i);
            #1;
            check("fill_en",   32'(en_wr), 32'd1);
            check("fill_addr", 32'(addr_wr), 32'(i));
            check("fill_data", 32'(data_wr), 32'(8'hA0 + i));
            check("fill_full_pre", 32'(full), 32'd0);
            tick();
        end
        check("full_set",   32'(full), 32'd1);
        check("full_used",  32'(used), 32'd16);
        check("full_gray",  32'(wr_ptr_gray), 32'b11000);
        check("full_afull", 32'(almost_full), 32'd1);
        check("full_ovf0",  32'(overflow), 32'd0);

        // 17th push is dropped.
        push_data = 8'h5A;
        #1;
        check("drop_en",   32'(en_wr), 32'd0);
        check("drop_addr", 32'(addr_wr), 32'd0);
        tick();
        check("drop_ovf",  32'(overflow), 32'd1);
        check("drop_gray", 32'(wr_ptr_gray), 32'b11000);
        check("drop_used", 32'(used), 32'd16);

        // Overflow clear, then clear racing a dropped push.
        push    = 1'b0;
        clr_ovf = 1'b1;
        tick();
        check("clr_ovf", 32'(overflow), 32'd0);
        push    = 1'b1;
        clr_ovf = 1'b0;
        tick();
        check("reset_ovf", 32'(overflow), 32'd1);
        clr_ovf = 1'b1;
        tick();
        check("clr_vs_set", 32'(overflow), 32'd1);
        push = 1'b0;
        tick();
        check("clr_again", 32'(overflow), 32'd0);
        clr_ovf = 1'b0;

        // Read pointer advances to 4; status follows three edges later.
        rd_drv = 5'b00110;
        tick();
        check("rd_e1_full", 32'(full), 32'd1);
        check("rd_e1_used", 32'(used), 32'd16);
        tick();
        check("rd_e2_full", 32'(full), 32'd1);
        check("rd_e2_used", 32'(used), 32'd16);
        tick();
        check("rd_e3_full",  32'(full), 32'd0);
        check("rd_e3_used",  32'(used), 32'd12);
        check("rd_e3_afull", 32'(almost_full), 32'd0);

        // Almost-full threshold.
        rd_drv = '0;
        rst = 1'b1;
        #2;
        rst = 1'b0;
        push = 1'b1;
        for (int i = 0; i < 13; i++) tick();
        check("af13_used",  32'(used), 32'd13);
        check("af13_afull", 32'(almost_full), 32'd0);
        tick();
        check("af14_used",  32'(used), 32'd14);
        check("af14_afull", 32'(almost_full), 32'd1);
        check("af14_full",  32'(full), 32'd0);

        // Reader tracks writer over 40 pushes, two pointer laps plus.
        push = 1'b0;
        rst  = 1'b1;
        #2;
        track = 1'b1;
        rst   = 1'b0;
        push  = 1'b1;
        for (int i = 0; i < 40; i++) begin
            int   p;
            ptr_t g;
            push_data = data_t'(i);
            #1;
            check("trk_en",   32'(en_wr), 32'd1);
            check("trk_addr", 32'(addr_wr), 32'(i % 16));
            check("trk_full", 32'(full), 32'd0);
            tick();
            p = (i + 1) % 32;
            g = ptr_t'(p ^ (p >> 1));
            check("trk_gray", 32'(wr_ptr_gray), 32'(g));
            if (i == 15) check("trk_msb16", 32'(wr_ptr_gray[W_ADDR]), 32'd1);
            if (i == 31) check("trk_wrap32", 32'(wr_ptr_gray), 32'd0);
        end

        // Asynchronous reset between edges while push stays high.
        #3;
        rst = 1'b1;
        #1;
        check("arst_en",   32'(en_wr), 32'd0);
        check("arst_full", 32'(full), 32'd0);
        check("arst_used", 32'(used), 32'd0);
        check("arst_ovf",  32'(overflow), 32'd0);
        check("arst_gray", 32'(wr_ptr_gray), 32'd0);
        #1;
        rst = 1'b0;
        #1;
        check("post_en",   32'(en_wr), 32'd1);
        check("post_addr", 32'(addr_wr), 32'd0);
        tick();
        check("post_gray", 32'(wr_ptr_gray), 32'b00001);
        check("post_used", 32'(used), 32'd1);
        push = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
